// File: rtl/vid_pkg.sv
// Shared video types: active-area constants, RGB444/888 types, colour-bar table and 4->8 bit expansion.
package vid_pkg;

  localparam int H_ACTIVE = 1920;
  localparam int V_ACTIVE = 1080;
  localparam int BAR_W    = H_ACTIVE / 8;

  typedef logic [11:0] rgb444_t;
  typedef logic [23:0] rgb888_t;

  typedef enum logic {WAIT_FRAME, RUN} fetch_state_e;

  // Index 0 is the left-most bar.
  localparam logic [7:0][11:0] BAR_TABLE = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  // Sideband that travels alongside the frame-buffer read.
  typedef struct packed {
    logic       run;
    logic       in_win;
    logic       mode;
    logic [2:0] bar_idx;
    logic       blank_n;
    logic       hsync;
    logic       vsync;
  } pix_side_t;

  function automatic rgb888_t rgb_expand(input rgb444_t c);
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

endpackage

// File: rtl/vid_delay_line.sv
// Resettable DEPTH-stage shift register for aligning sideband with pixel data.
// Latency DEPTH cycles; no backpressure (advances every clock).
module vid_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe_q <= '0;
    else      pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_frame_fetch.sv
// Frame-buffer fetch with 2x upscale into a centred window, border fill and colour-bar test pattern.
// Latency 2+RAM_LAT cycles from timing inputs to DAC outputs; free-running, no backpressure.
module vga_frame_fetch
  import vid_pkg::*;
#(
  parameter int          IMG_W   = 640,
  parameter int          IMG_H   = 480,
  parameter int          X_OFF   = 320,
  parameter int          Y_OFF   = 60,
  parameter int          RAM_LAT = 1,
  parameter logic [11:0] BORDER  = 12'h000,
  parameter int          ADDR_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       hcnt,
  input  logic [11:0]       vcnt,
  input  logic              blank_n_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              test_en,
  output logic [ADDR_W-1:0] frame_addr,
  input  logic [11:0]       frame_pixel,
  output logic [7:0]        vga_red,
  output logic [7:0]        vga_green,
  output logic [7:0]        vga_blue,
  output logic              blank_n_out,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam logic [11:0] X_START = 12'(X_OFF);
  localparam logic [11:0] X_END   = 12'(X_OFF + 2 * IMG_W);
  localparam logic [11:0] Y_START = 12'(Y_OFF);
  localparam logic [11:0] Y_END   = 12'(Y_OFF + 2 * IMG_H);

  fetch_state_e      state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] frame_addr_q, frame_addr_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [7:0]        bar_px_q, bar_px_d;
  rgb888_t           rgb_q, rgb_d;
  logic              blank_n_out_q, blank_n_out_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;

  logic       frame_start, in_win, y_odd;
  logic [10:0] col;
  pix_side_t  side_in, side_out;
  rgb444_t    pix_sel;

  assign frame_start = (hcnt == '0) && (vcnt == '0);
  assign in_win = (hcnt >= X_START) && (hcnt < X_END) && (vcnt >= Y_START) && (vcnt < Y_END);
  assign col    = 11'((hcnt - X_START) >> 1);
  // LSB of (vcnt - Y_OFF) without a full subtractor.
  assign y_odd  = vcnt[0] ^ 1'(Y_OFF % 2);

  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_FRAME && frame_start) state_d = RUN;
  end

  always_comb begin
    mode_d       = frame_start ? test_en : mode_q;
    frame_addr_d = in_win ? (row_base_q + ADDR_W'(col)) : frame_addr_q;
    row_base_d   = row_base_q;
    if (frame_start) begin
      row_base_d = '0;
    end else if (in_win && hcnt == X_END - 12'd1 && y_odd) begin
      row_base_d = row_base_q + ADDR_W'(IMG_W);
    end
  end

  // Bar position tracked incrementally; assumes hcnt steps by one along a line.
  always_comb begin
    if (hcnt == '0) begin
      bar_idx_d = '0;
      bar_px_d  = '0;
    end else if (bar_px_q == 8'(BAR_W - 1)) begin
      bar_idx_d = bar_idx_q + 3'd1;
      bar_px_d  = '0;
    end else begin
      bar_idx_d = bar_idx_q;
      bar_px_d  = bar_px_q + 8'd1;
    end
  end

  always_comb begin
    side_in         = '0;
    side_in.run     = (state_q == RUN) || frame_start;
    side_in.in_win  = in_win;
    side_in.mode    = mode_d;
    side_in.bar_idx = bar_idx_d;
    side_in.blank_n = blank_n_in;
    side_in.hsync   = hsync_in;
    side_in.vsync   = vsync_in;
  end

  vid_delay_line #(
    .DEPTH (1 + RAM_LAT),
    .WIDTH ($bits(pix_side_t))
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  (side_in),
    .dout (side_out)
  );

  always_comb begin
    blank_n_out_d = side_out.run & side_out.blank_n;
    hsync_d       = side_out.hsync;
    vsync_d       = side_out.vsync;
    if (side_out.mode)        pix_sel = BAR_TABLE[side_out.bar_idx];
    else if (side_out.in_win) pix_sel = frame_pixel;
    else                      pix_sel = BORDER;
    rgb_d = blank_n_out_d ? rgb_expand(pix_sel) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= WAIT_FRAME;
      mode_q        <= 1'b0;
      row_base_q    <= '0;
      frame_addr_q  <= '0;
      bar_idx_q     <= '0;
      bar_px_q      <= '0;
      rgb_q         <= '0;
      blank_n_out_q <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      row_base_q    <= row_base_d;
      frame_addr_q  <= frame_addr_d;
      bar_idx_q     <= bar_idx_d;
      bar_px_q      <= bar_px_d;
      rgb_q         <= rgb_d;
      blank_n_out_q <= blank_n_out_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign frame_addr  = frame_addr_q;
  assign vga_red     = rgb_q[23:16];
  assign vga_green   = rgb_q[15:8];
  assign vga_blue    = rgb_q[7:0];
  assign blank_n_out = blank_n_out_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;

endmodule
